jk_counter: RTL
===============

JK_COUNTER -- requirements
Module: jk_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value; counting range 0..MAX_VAL (legal range 1..2**WIDTH-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 load_val  input  WIDTH  value captured on load.
REQ-008 en  input  1  count enable.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 q  output  WIDTH  current count, driven directly by the flip-flop outputs.
REQ-011 tc  output  1  terminal-count indication, combinational.
REQ-012 wrap  output  1  sticky wrap flag, registered.

Function
REQ-013 Every state bit SHALL be a JK flip-flop cell; per-bit next state SHALL be realised as J=K=(q[i] XOR next[i]), so each bit either holds or toggles.
REQ-014 Priority per rising edge SHALL be clr > load > en > hold.
REQ-015 clr=1 SHALL set q to 0 and wrap to 0 on the next edge.
REQ-016 load=1 (clr=0) SHALL set q to min(load_val, MAX_VAL) on the next edge and leave wrap unchanged.
REQ-017 en=1, up=1 (clr=0, load=0) SHALL set q to q+1, or to 0 when q==MAX_VAL.
REQ-018 en=1, up=0 (clr=0, load=0) SHALL set q to q-1, or to MAX_VAL when q==0.
REQ-019 en=0 (clr=0, load=0) SHALL hold q and wrap.
REQ-020 Count latency SHALL be exactly one clock from the enabling edge to the updated q.
REQ-021 tc SHALL equal en & ~clr & ~load & ((up & q==MAX_VAL) | (~up & q==0)).
REQ-022 wrap SHALL set to 1 on any edge where tc==1 and SHALL clear only on clr or reset.
REQ-023 An up/down change SHALL take effect on the next edge with no dead cycle.
REQ-024 If q is ever above MAX_VAL (unreachable in normal use), the next enabled count SHALL load 0 for up and MAX_VAL for down.
REQ-025 All arithmetic SHALL be WIDTH bits, with no intermediate carry exposed on any output.

Reset
REQ-026 rst_n=0 SHALL force q=0 and wrap=0 immediately, independent of clk.
REQ-027 Assertion of rst_n=0 mid-count SHALL discard the in-flight update.
REQ-028 The first edge after rst_n deassertion SHALL perform normal operation according to REQ-014.
REQ-029 tc SHALL follow REQ-021 during reset, so with q=0 it reads 1 only if en=1, up=0 and no clr or load.

Structure
REQ-030 The shared package SHALL hold the mode encoding constants (UP=1, DOWN=0) and the WIDTH and MAX_VAL defaults.
REQ-031 There SHALL be one sub-module, jk_cell (ports: clk, rst_n, j, k, q), instantiated WIDTH times via generate.
REQ-032 jk_cell SHALL implement the full JK truth table: 00 hold, 01 reset, 10 set, 11 toggle, with asynchronous active-low reset to 0.
REQ-033 Next-state logic, load clamping, tc and wrap SHALL reside in jk_counter.

Verification (WIDTH=4, MAX_VAL=9)
REQ-034 Reset then en=1, up=1 for 12 edges -> q sequence 1..9,0,1,2; tc=1 only while q==9; wrap=1 from the edge leaving 9.
REQ-035 Down-count: load_val=2 load, then en=1, up=0 for 4 edges -> q 2,1,0,9,8; tc=1 while q==0; wrap sets.
REQ-036 Priority: clr=1, load=1, en=1, load_val=5 with q=7 -> q=0 and wrap=0 next edge; then load=1, en=1, load_val=5 -> q=5 (load beats count); load_val=14 -> q=9 (clamp).
REQ-037 Async reset: pulse rst_n low for 3 ns mid-cycle with q=6 -> q=0 and wrap=0 before the next edge; count resumes from 0 at the first edge after release.
REQ-038 Direction and hold: q=4, toggle up every edge with en=1 -> q 5,4,5,4; en=0 for 3 edges -> q holds; tc stays 0 throughout.
REQ-039 jk_cell unit check: apply j/k = 01, 10, 10, 00, 11, 00 on successive edges -> q 0,1,1,1,0,0.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// ============================================================================
// jk_counter_pkg : shared mode encodings and parameter defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package jk_counter_pkg;

  localparam int   DEFAULT_WIDTH = 4;
  localparam logic MODE_UP       = 1'b1;
  localparam logic MODE_DOWN     = 1'b0;

  // Default terminal value is the all-ones word of the chosen width.
  function automatic logic [31:0] default_max_val(input int width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// jk_cell : single JK flip-flop, asynchronous active-low reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_counter.sv
// ============================================================================
// jk_counter : modulo up/down counter built from JK cells, with clear, clamped
//              load, combinational terminal count and sticky wrap flag
// Rev 1.0
// ============================================================================
`default_nettype none

module jk_counter
  import jk_counter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VAL = WIDTH'(default_max_val(WIDTH))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] jk;
  logic             at_max;
  logic             at_zero;
  logic             over_max;
  logic             count_up;

  assign at_max       = (q == MAX_VAL);
  assign at_zero      = (q == ZERO);
  assign over_max     = (q > MAX_VAL);
  assign count_up     = (up == MODE_UP);
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Out-of-range states recover to the boundary of the counting direction.
  always_comb begin
    next_q = q;
    if (clr) begin
      next_q = ZERO;
    end else if (load) begin
      next_q = load_clamped;
    end else if (en) begin
      if (count_up) begin
        next_q = (at_max || over_max) ? ZERO : q + ONE;
      end else begin
        next_q = (at_zero || over_max) ? MAX_VAL : q - ONE;
      end
    end
  end

  assign tc = en & ~clr & ~load & ((count_up & at_max) | (~count_up & at_zero));

  // J=K=(q^next): each bit either holds (00) or toggles (11).
  assign jk = q ^ next_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (jk[i]),
      .k     (jk[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else if (clr) begin
      wrap <= 1'b0;
    end else if (tc) begin
      wrap <= 1'b1;
    end
  end

endmodule

`default_nettype wire
